ft245_rx_deframer: RTL

Receive-side deframer directly downstream of the FT245 FIFO block: consumes the byte stream from its simple-interface RX port (`rx_data_si` / `rx_valid_si` / `rx_ready_si`) and extracts framed 16-bit sample words for the modulator datapath. It hunts for a sync byte and reads a length byte. It packs little-endian payload bytes into words and checks an XOR checksum. A stall timeout aborts partial frames. It reports per-frame status pulses and a saturating error counter.

---
 rtl/ft245_rx_deframer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ft245_rx_deframer.sv
// Byte-stream deframer: hunts SYNC, reads LEN, packs little-endian 16-bit words,
// checks the XOR checksum and aborts frames that stall with no input bytes.
module ft245_rx_deframer #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_si,
  input  logic        rx_valid_si,
  output logic        rx_ready_si,
  output logic [15:0] sample_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        sample_last,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [7:0]  err_count
);

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_LO, S_HI, S_CHK} state_t;

  state_t      state_q, state_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [7:0]  xor_q, xor_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic [7:0]  errcnt_q, errcnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic        accept, timeout;

  // Only the HI byte writes the output register, so only HI can be stalled.
  assign rx_ready_si = (state_q == S_HI) ? (!valid_q || sample_ready) : 1'b1;
  assign accept      = rx_valid_si && rx_ready_si;
  assign timeout     = (state_q != S_HUNT) && !rx_valid_si &&
                       (({1'b0, tmo_q} + 17'd1) == 17'(TIMEOUT_CYCLES));

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    xor_d    = xor_q;
    lo_d     = lo_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    errcnt_d = errcnt_q;
    tmo_d    = tmo_q;

    if (valid_q && sample_ready) valid_d = 1'b0;

    if (state_q == S_HUNT || accept) tmo_d = '0;
    else if (!rx_valid_si)           tmo_d = tmo_q + 16'd1;

    case (state_q)
      S_HUNT: if (accept && rx_data_si == SYNC_BYTE) state_d = S_LEN;
      S_LEN: if (accept) begin
        wcnt_d  = rx_data_si;
        xor_d   = 8'h00;
        state_d = (rx_data_si == 8'h00) ? S_CHK : S_LO;
      end
      S_LO: if (accept) begin
        lo_d    = rx_data_si;
        xor_d   = xor_q ^ rx_data_si;
        state_d = S_HI;
      end
      S_HI: if (accept) begin
        data_d  = {rx_data_si, lo_q};
        valid_d = 1'b1;
        last_d  = (wcnt_q == 8'd1);
        xor_d   = xor_q ^ rx_data_si;
        wcnt_d  = wcnt_q - 8'd1;
        state_d = (wcnt_q == 8'd1) ? S_CHK : S_LO;
      end
      S_CHK: if (accept) begin
        ok_d    = (rx_data_si == xor_q);
        err_d   = (rx_data_si != xor_q);
        state_d = S_HUNT;
      end
      default: state_d = S_HUNT;
    endcase

    // Never coincides with an accept; a pending word is left to drain.
    if (timeout) begin
      err_d   = 1'b1;
      state_d = S_HUNT;
      tmo_d   = '0;
    end

    if (err_d && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_HUNT;
      wcnt_q   <= '0;
      xor_q    <= '0;
      lo_q     <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      xor_q    <= xor_d;
      lo_q     <= lo_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
      tmo_q    <= tmo_d;
    end
  end

  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign sample_last  = last_q;
  assign frame_ok     = ok_q;
  assign frame_err    = err_q;
  assign err_count    = errcnt_q;

endmodule
